// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one uarttx from NUM_REQ byte requesters.
// Define TX_TIMEOUT_EN to add the donetx watchdog and the timeout_err pulse.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CLK_FREQ       = 1000000,
  parameter int BAUD_RATE      = 9600,
  parameter int TIMEOUT_CYCLES = 2 * 10 * (CLK_FREQ / BAUD_RATE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       newd,
  output logic [7:0]                 tx_data,
  input  logic                       donetx,
  output logic                       timeout_err
);
  localparam int IW           = $clog2(NUM_REQ);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_tx_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, RELEASE} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] ack_q, ack_d, elig;
  logic [IW-1:0]      gid_q, gid_d, ptr_q, ptr_d, win, idx;
  logic [7:0]         data_q, data_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               newd_q, newd_d, busy_q, busy_d, mask_q, mask_d;
  logic               donetx_q, done_edge, found, tmo_hit;

  assign done_edge = donetx & ~donetx_q;

  // Search from ptr_q (the requester after the last winner), wrapping.
  // The just-acked requester sits out the first IDLE cycle after RELEASE.
  always_comb begin
    elig = req;
    if (mask_q) elig[gid_q] = 1'b0;
    win   = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IW'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    newd_d  = newd_q;
    busy_d  = busy_q;
    ack_d   = '0;
    gid_d   = gid_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    mask_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LAUNCH;
          newd_d  = 1'b1;
          busy_d  = 1'b1;
          gid_d   = win;
          data_d  = req_data[8*win +: 8];
          ptr_d   = IW'((int'(win) + 1) % NUM_REQ);
          cnt_d   = '0;
        end
      end
      LAUNCH, WAIT_DONE: begin
        if (done_edge) begin
          state_d        = RELEASE;
          newd_d         = 1'b0;
          ack_d[gid_q]   = 1'b1;
        end else if (tmo_hit) begin
          state_d = IDLE;
          newd_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (state_q == LAUNCH) begin
          // newd spans a full bit time so uarttx sees at least one uclk edge
          if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            state_d = WAIT_DONE;
            newd_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RELEASE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        mask_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      newd_q   <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= '0;
      gid_q    <= '0;
      data_q   <= '0;
      ptr_q    <= '0;
      mask_q   <= 1'b0;
      cnt_q    <= '0;
      donetx_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      newd_q   <= newd_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      gid_q    <= gid_d;
      data_q   <= data_d;
      ptr_q    <= ptr_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      donetx_q <= donetx;
    end
  end

`ifdef TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          terr_q, terr_d;

  // Counter is zero on LAUNCH entry because LAUNCH is only reached from IDLE.
  assign tmo_hit = (state_q == LAUNCH || state_q == WAIT_DONE) &&
                   (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d  = tmo_q;
    if (state_q == IDLE) tmo_d = '0;
    else if (state_q == LAUNCH || state_q == WAIT_DONE) tmo_d = tmo_q + 1'b1;
    terr_d = tmo_hit & ~done_edge;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign ack      = ack_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;
  assign newd     = newd_q;
  assign tx_data  = data_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter sharing one uarttx transmitter among NUM_REQ byte requesters.
- Latches the winning requester's byte and drives the transmitter's newd/tx_data.
- Waits for donetx, then returns a one-cycle ack to the granted requester.
- Sits between client blocks (status reporters, debug streamers) and the single UART TX pin.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CLK_FREQ, 1000000, system clock frequency in Hz (matches uarttx).
- BAUD_RATE, 9600, baud rate (matches uarttx); CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division).
- TIMEOUT_CYCLES, 2*10*CLKS_PER_BIT, watchdog limit; used only with TX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_data  in  8*NUM_REQ  byte for requester i in bits [8i+7:8i]; stable while req[i]=1.
- ack  out  NUM_REQ  one-cycle pulse; byte of requester i fully sent.
- busy  out  1  high in every state except IDLE.
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester.
- newd  out  1  to uarttx newd.
- tx_data  out  8  to uarttx tx_data.
- donetx  in  1  from uarttx donetx.
- timeout_err  out  1  one-cycle watchdog pulse (tied 0 without the macro).

Behaviour:
- Reset (async, immediate): state=IDLE; newd, tx_data, ack, busy, grant_id, timeout_err = 0; RR pointer = 0; donetx edge register = 0.
- All outputs are registered.
- States: IDLE -> LAUNCH -> WAIT_DONE -> RELEASE -> IDLE.
- IDLE:
  - If any eligible req is high, pick the first set bit searching from (last_grant+1) mod NUM_REQ, wrapping.
  - Next cycle: grant_id=winner, tx_data=req_data[winner], newd=1, busy=1, state=LAUNCH.
  - Latency from req high (arbiter idle) to newd high: 1 clk.
  - Only req is sampled; tx_data stays latched for the whole transfer.
- RR pointer:
  - After reset, requester 0 has top priority.
  - Pointer updates to the winner when the grant is issued.
- LAUNCH:
  - newd held high for exactly CLKS_PER_BIT clks, guaranteeing one uclk edge inside uarttx.
  - Then newd=0 and state=WAIT_DONE.
- donetx detection:
  - A rising edge of donetx (registered compare) is detected in LAUNCH or WAIT_DONE.
  - An edge in LAUNCH drops newd immediately and goes to RELEASE.
  - Level-high donetx at LAUNCH entry is not treated as done; only a rising edge counts.
- WAIT_DONE: on a donetx rising edge, go to RELEASE.
- RELEASE (1 clk):
  - ack[grant_id]=1 for this cycle only; next state IDLE.
  - busy drops to 0 on entry to IDLE.
- Eligibility:
  - In the IDLE cycle immediately after RELEASE, the just-acked requester is masked.
  - This gives it one cycle to drop req; if req is still high afterwards, it is a new request at lowest RR priority.
- Requester drops req mid-transfer: the transfer completes and ack still pulses (byte already latched).
- Single requester continuous: back-to-back bytes; the gap is 2 clks of IDLE (1 masked cycle + 1 arbitration cycle) plus LAUNCH.
- Reset mid-transfer: returns to IDLE immediately, newd=0, no ack. uarttx resets on the same rst.

Optional Feature:
- Macro: TX_TIMEOUT_EN.
- With it defined:
  - A cycle counter clears on LAUNCH entry and counts in LAUNCH and WAIT_DONE.
  - When the count reaches TIMEOUT_CYCLES with no donetx edge: newd=0, timeout_err=1 for 1 clk, no ack, state -> IDLE.
  - grant_id holds the failed id during the pulse; the RR pointer still advances past it.
  - A donetx edge in the same cycle as the limit wins: normal ack, no error.
- Without it: no counter; WAIT_DONE waits indefinitely; timeout_err is constant 0.

Test Plan:
1. Bench setup: NUM_REQ=4, CLK_FREQ=1000000, BAUD_RATE=9600 (CLKS_PER_BIT=104), real uarttx.
2. Single request: req=4'b0100, byte 0xA5 -> next clk newd=1, tx_data=0xA5, grant_id=2; newd high exactly 104 clks; serial line decodes 0xA5; ack=4'b0100 for 1 clk after donetx rises.
3. Contention: req=4'b1111 simultaneously from reset, each held until its ack -> grant order 0,1,2,3; each ack exactly once; bytes on the line in that order.
4. Fairness/mask: req[1] held permanently high, req[3] pulsed high after the first grant -> order 1,3,1,...; req[1] never granted in the cycle right after its own ack.
5. Reset mid-transfer: assert rst 300 clks into WAIT_DONE -> same cycle newd=0, busy=0, ack=0; after release, pending req=4'b0001 is granted with grant_id=0.
6. TX_TIMEOUT_EN with TIMEOUT_CYCLES=500 and donetx forced 0 -> timeout_err pulses exactly 500 clks after LAUNCH entry, no ack, busy=0 the next clk; without the macro, the same stimulus leaves busy=1 indefinitely.
